lab9_soc_timer_driver: RTL

LAB9_SOC_TIMER_DRIVER -- requirements
Module: lab9_soc_timer_driver

---
 rtl/lab9_soc_timer_driver_pkg.sv | 62 ++++++
 rtl/lab9_soc_timer_driver_if.sv | 19 +
 rtl/lab9_soc_timer_driver.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lab9_soc_timer_driver_pkg.sv
// Shared types and constants for the timer driver: FSM states, timer register map,
// control words and the bus-request encoding used by the driver.
package lab9_soc_timer_driver_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StWrPl,
    StWrPh,
    StWrCtl,
    StRun,
    StClrSt,
    StSnapWr,
    StSnapRl,
    StSnapRh,
    StSnapCap,
    StStopWr
  } state_e;

  localparam logic [2:0] AddrStatus  = 3'd0;
  localparam logic [2:0] AddrControl = 3'd1;
  localparam logic [2:0] AddrPeriodL = 3'd2;
  localparam logic [2:0] AddrPeriodH = 3'd3;
  localparam logic [2:0] AddrSnapL   = 3'd4;
  localparam logic [2:0] AddrSnapH   = 3'd5;

  localparam int unsigned CtrlItoBit   = 0;
  localparam int unsigned CtrlContBit  = 1;
  localparam int unsigned CtrlStartBit = 2;
  localparam int unsigned CtrlStopBit  = 3;

  localparam logic [15:0] CtrlStartWord =
      16'((1 << CtrlItoBit) | (1 << CtrlContBit) | (1 << CtrlStartBit));
  localparam logic [15:0] CtrlStopWord = 16'(1 << CtrlStopBit);

  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_req_t;

  localparam bus_req_t BusIdle = '{cs: 1'b0, write_n: 1'b1, addr: AddrStatus, data: 16'h0000};

  function automatic bus_req_t bus_wr(logic [2:0] addr, logic [15:0] data);
    bus_req_t r;
    r.cs      = 1'b1;
    r.write_n = 1'b0;
    r.addr    = addr;
    r.data    = data;
    return r;
  endfunction

  function automatic bus_req_t bus_rd(logic [2:0] addr);
    bus_req_t r;
    r.cs      = 1'b1;
    r.write_n = 1'b1;
    r.addr    = addr;
    r.data    = 16'h0000;
    return r;
  endfunction

endpackage

// File: rtl/lab9_soc_timer_driver_if.sv
// Avalon-MM style timer bus plus the timer interrupt line.
interface lab9_soc_timer_driver_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        irq_in;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, irq_in
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, irq_in
  );
endinterface

// File: rtl/lab9_soc_timer_driver.sv
// Timer session driver: programs the period, services timeouts, takes snapshots and
// stops the timer on request or after a tick budget. All outputs are registered.
module lab9_soc_timer_driver
  import lab9_soc_timer_driver_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [31:0] cmd_period,
  input  logic [15:0] cmd_ticks,
  input  logic        cmd_stop,
  input  logic        snap_req,
  output logic        busy,
  output logic        cmd_err,
  output logic        done,
  output logic [15:0] tick_count,
  output logic        snap_valid,
  output logic [31:0] snap_value,
  lab9_soc_timer_driver_if.master avm
);

  state_e      state_q;
  bus_req_t    bus_q;
  logic [31:0] period_q;
  logic [15:0] ticks_q;
  logic [15:0] snap_lo_q;
  logic        irq_mask_q;

  assign avm.avm_chipselect = bus_q.cs;
  assign avm.avm_write_n    = bus_q.write_n;
  assign avm.avm_address    = bus_q.addr;
  assign avm.avm_writedata  = bus_q.data;

  // Bus request is registered on the edge that enters the state performing the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bus_q      <= BusIdle;
      period_q   <= '0;
      ticks_q    <= '0;
      snap_lo_q  <= '0;
      irq_mask_q <= 1'b0;
      busy       <= 1'b0;
      cmd_err    <= 1'b0;
      done       <= 1'b0;
      tick_count <= '0;
      snap_valid <= 1'b0;
      snap_value <= '0;
    end else begin
      bus_q      <= BusIdle;
      cmd_err    <= 1'b0;
      done       <= 1'b0;
      snap_valid <= 1'b0;
      irq_mask_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_start) begin
            if (cmd_period == '0) begin
              cmd_err <= 1'b1;
            end else begin
              period_q   <= cmd_period;
              ticks_q    <= cmd_ticks;
              tick_count <= '0;
              busy       <= 1'b1;
              state_q    <= StWrPl;
              bus_q      <= bus_wr(AddrPeriodL, cmd_period[15:0]);
            end
          end
        end
        StWrPl: begin
          state_q <= StWrPh;
          bus_q   <= bus_wr(AddrPeriodH, period_q[31:16]);
        end
        StWrPh: begin
          state_q <= StWrCtl;
          bus_q   <= bus_wr(AddrControl, CtrlStartWord);
        end
        StWrCtl: state_q <= StRun;
        StRun: begin
          // The slave drops irq one cycle after the status write, so skip that cycle.
          if (avm.irq_in && !irq_mask_q) begin
            state_q    <= StClrSt;
            bus_q      <= bus_wr(AddrStatus, 16'h0000);
            tick_count <= tick_count + 16'd1;
          end else if (cmd_stop) begin
            state_q <= StStopWr;
            bus_q   <= bus_wr(AddrControl, CtrlStopWord);
          end else if (snap_req) begin
            state_q <= StSnapWr;
            bus_q   <= bus_wr(AddrSnapL, 16'h0000);
          end
        end
        StClrSt: begin
          if (ticks_q != '0 && tick_count == ticks_q) begin
            state_q <= StStopWr;
            bus_q   <= bus_wr(AddrControl, CtrlStopWord);
          end else begin
            state_q    <= StRun;
            irq_mask_q <= 1'b1;
          end
        end
        StSnapWr: begin
          state_q <= StSnapRl;
          bus_q   <= bus_rd(AddrSnapL);
        end
        StSnapRl: begin
          state_q <= StSnapRh;
          bus_q   <= bus_rd(AddrSnapH);
        end
        StSnapRh: begin
          snap_lo_q <= avm.avm_readdata;
          state_q   <= StSnapCap;
        end
        StSnapCap: begin
          snap_value <= {avm.avm_readdata, snap_lo_q};
          snap_valid <= 1'b1;
          state_q    <= StRun;
        end
        StStopWr: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
